// File: rtl/hedios_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one byte-wide UART TX path
// between N_REQ requesters, with an idle-mid-frame watchdog.
module hedios_tx_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  in_data,
  input  logic [N_REQ-1:0]         in_valid,
  input  logic [N_REQ-1:0]         in_last,
  output logic [N_REQ-1:0]         in_ready,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic                     abort,
  output logic [$clog2(N_REQ)-1:0] abort_id
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [SUM_W-1:0] N_SUM     = SUM_W'(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic [PTR_W-1:0]   abort_id_q, abort_id_d;

  logic [DATA_W-1:0]  lane [N_REQ];
  logic               own_valid;
  logic               own_last;
  logic               xfer;
  logic [PTR_W-1:0]   ptr_inc;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [SUM_W-1:0]   sum;
  logic [PTR_W-1:0]   cand;

  // Unpack the flat data bus into per-requester byte lanes
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign lane[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  assign busy     = (state_q == S_OWN);
  assign grant    = grant_q;
  assign abort    = abort_q;
  assign abort_id = abort_id_q;

  assign own_valid = in_valid[owner_q];
  assign own_last  = in_last[owner_q];
  assign ptr_inc   = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);

  // Combinational pass-through of the owner's lane to the transmitter
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    in_ready = '0;
    if (busy) begin
      tx_data  = lane[owner_q];
      tx_valid = own_valid;
      in_ready = N_REQ'(tx_ready) << owner_q;
    end
  end

  assign xfer = tx_valid & tx_ready;

  // Round-robin pick: first requesting index at or above rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (sum >= N_SUM) begin
        sum = sum - N_SUM;
      end
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state: grant acquisition, frame completion and watchdog revocation
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    abort_d    = 1'b0;
    abort_id_d = abort_id_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = S_OWN;
          owner_d = pick;
          grant_d = N_REQ'(1) << pick;
        end
      end
      S_OWN: begin
        if (xfer && own_last) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          rr_ptr_d = ptr_inc;
          cnt_d    = '0;
        end else if (own_valid) begin
          // Valid bytes, including back-pressured ones, keep the grant alive
          cnt_d = '0;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LIMIT)) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          rr_ptr_d   = ptr_inc;
          cnt_d      = '0;
          abort_d    = 1'b1;
          abort_id_d = owner_q;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; async reset drops the grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      abort_id_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      abort_id_q <= abort_id_d;
    end
  end

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// Directed bench for hedios_tx_arbiter: vector table plus multi-cycle
// watchdog and asynchronous-reset sequences.
module tb_hedios_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] in_data = '0;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_last = '0;
  logic        tx_ready = 1'b0;

  logic [2:0]  in_ready, grant;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, abort;
  logic [1:0]  abort_id;

  logic [2:0]  in_ready0, grant0;
  logic [7:0]  tx_data0;
  logic        tx_valid0, busy0, abort0;
  logic [1:0]  abort_id0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hedios_tx_arbiter #(.N_REQ(3), .DATA_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .abort(abort), .abort_id(abort_id)
  );

  hedios_tx_arbiter #(.N_REQ(3), .DATA_W(8), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .grant(grant0), .busy(busy0), .abort(abort0), .abort_id(abort_id0)
  );

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  vld;
    logic [2:0]  lst;
    logic [23:0] dat;
    logic        trdy;
    logic [2:0]  e_gnt;
    logic        e_busy;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [2:0]  e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] v,
                              input logic [2:0] l, input logic [23:0] d,
                              input logic t, input logic [2:0] g,
                              input logic b, input logic xv,
                              input logic [7:0] xd, input logic [2:0] rd);
    vec_t x;
    x.req = r; x.vld = v; x.lst = l; x.dat = d; x.trdy = t;
    x.e_gnt = g; x.e_busy = b; x.e_txv = xv; x.e_txd = xd; x.e_rdy = rd;
    return x;
  endfunction

  // Expected output bundle {grant, busy, tx_valid, tx_data, in_ready, abort}
  function automatic logic [16:0] exp_o(input logic [2:0] g, input logic b,
                                        input logic v, input logic [7:0] d,
                                        input logic [2:0] r, input logic a);
    return {g, b, v, d, r, a};
  endfunction

  task automatic chk(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {grant, busy, tx_valid, tx_data, in_ready, abort};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {gnt,busy,txv,txd,rdy,abort}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] v, input logic [2:0] l,
                       input logic [23:0] d, input logic t);
    req = r; in_valid = v; in_last = l; in_data = d; tx_ready = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic seen0;
    logic seen8;

    // Single frame on lane 1, then rr_ptr=2 check via req=110
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, 24'h000000, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b010, 3'b010, 3'b000, 24'h00A500, 1, 3'b010, 1, 1, 8'hA5, 3'b010));
    tbl.push_back(mk(3'b010, 3'b010, 3'b000, 24'h005A00, 1, 3'b010, 1, 1, 8'h5A, 3'b010));
    tbl.push_back(mk(3'b010, 3'b010, 3'b010, 24'h003C00, 1, 3'b010, 1, 1, 8'h3C, 3'b010));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 24'h000000, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b110, 3'b000, 3'b000, 24'h000000, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b110, 3'b100, 3'b100, 24'h770000, 1, 3'b100, 1, 1, 8'h77, 3'b100));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 24'h000000, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    // Round-robin fairness, two-byte frames, all requesting
    tbl.push_back(mk(3'b111, 3'b000, 3'b000, 24'h121110, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 24'h121110, 1, 3'b001, 1, 1, 8'h10, 3'b001));
    tbl.push_back(mk(3'b111, 3'b111, 3'b111, 24'h121110, 1, 3'b001, 1, 1, 8'h10, 3'b001));
    tbl.push_back(mk(3'b111, 3'b000, 3'b000, 24'h121110, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 24'h121110, 1, 3'b010, 1, 1, 8'h11, 3'b010));
    tbl.push_back(mk(3'b111, 3'b111, 3'b111, 24'h121110, 1, 3'b010, 1, 1, 8'h11, 3'b010));
    tbl.push_back(mk(3'b111, 3'b000, 3'b000, 24'h121110, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 24'h121110, 1, 3'b100, 1, 1, 8'h12, 3'b100));
    tbl.push_back(mk(3'b111, 3'b111, 3'b111, 24'h121110, 1, 3'b100, 1, 1, 8'h12, 3'b100));
    tbl.push_back(mk(3'b111, 3'b000, 3'b000, 24'h121110, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b111, 3'b000, 3'b000, 24'h121110, 1, 3'b001, 1, 0, 8'h10, 3'b001));
    tbl.push_back(mk(3'b000, 3'b001, 3'b001, 24'h121110, 1, 3'b001, 1, 1, 8'h10, 3'b001));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 24'h121110, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    // Atomicity under back-pressure with req[2] rising mid-frame
    tbl.push_back(mk(3'b001, 3'b000, 3'b000, 24'h000021, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b001, 3'b001, 3'b000, 24'h000021, 1, 3'b001, 1, 1, 8'h21, 3'b001));
    tbl.push_back(mk(3'b101, 3'b101, 3'b000, 24'h000022, 0, 3'b001, 1, 1, 8'h22, 3'b000));
    tbl.push_back(mk(3'b100, 3'b101, 3'b001, 24'h000022, 0, 3'b001, 1, 1, 8'h22, 3'b000));
    tbl.push_back(mk(3'b100, 3'b001, 3'b001, 24'h000022, 1, 3'b001, 1, 1, 8'h22, 3'b001));
    tbl.push_back(mk(3'b100, 3'b000, 3'b000, 24'h330022, 1, 3'b000, 0, 0, 8'h00, 3'b000));
    tbl.push_back(mk(3'b100, 3'b100, 3'b100, 24'h330022, 1, 3'b100, 1, 1, 8'h33, 3'b100));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 24'h000000, 1, 3'b000, 0, 0, 8'h00, 3'b000));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", exp_o(3'b000, 0, 0, 8'h00, 3'b000, 0));
    chk_val("reset_abort_id", 32'(abort_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].vld, tbl[i].lst, tbl[i].dat, tbl[i].trdy);
      #1;
      chk($sformatf("vec%0d", i), exp_o(tbl[i].e_gnt, tbl[i].e_busy, tbl[i].e_txv,
                                        tbl[i].e_txd, tbl[i].e_rdy, 1'b0));
    end

    // Watchdog abort: requester 2 stalls after one byte
    @(negedge clk);
    drive(3'b100, 3'b000, 3'b000, 24'h440000, 1); #1;
    chk("wd_idle", exp_o(3'b000, 0, 0, 8'h00, 3'b000, 0));
    @(negedge clk);
    drive(3'b111, 3'b100, 3'b000, 24'h440000, 1); #1;
    chk("wd_byte", exp_o(3'b100, 1, 1, 8'h44, 3'b100, 0));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive(3'b111, 3'b000, 3'b000, 24'h440000, 1); #1;
      chk($sformatf("wd_hold%0d", k), exp_o(3'b100, 1, 0, 8'h44, 3'b100, 0));
    end
    @(negedge clk); #1;
    chk("wd_abort", exp_o(3'b000, 0, 0, 8'h00, 3'b000, 1));
    chk_val("wd_abort_id", 32'(abort_id), 32'd2);
    @(negedge clk); #1;
    chk("wd_regrant", exp_o(3'b001, 1, 0, 8'h00, 3'b001, 0));
    do_reset();

    // Watchdog boundary: valid returns exactly at count TIMEOUT-1
    @(negedge clk);
    drive(3'b001, 3'b000, 3'b000, 24'h000055, 1); #1;
    chk("bd_idle", exp_o(3'b000, 0, 0, 8'h00, 3'b000, 0));
    @(negedge clk);
    drive(3'b001, 3'b001, 3'b000, 24'h000055, 1); #1;
    chk("bd_byte0", exp_o(3'b001, 1, 1, 8'h55, 3'b001, 0));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      drive(3'b001, 3'b000, 3'b000, 24'h000055, 1); #1;
      chk($sformatf("bd_gap%0d", k), exp_o(3'b001, 1, 0, 8'h55, 3'b001, 0));
    end
    @(negedge clk);
    drive(3'b001, 3'b001, 3'b000, 24'h000055, 1); #1;
    chk("bd_rescue", exp_o(3'b001, 1, 1, 8'h55, 3'b001, 0));
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      drive(3'b001, 3'b000, 3'b000, 24'h000055, 1); #1;
      chk($sformatf("bd_after%0d", k), exp_o(3'b001, 1, 0, 8'h55, 3'b001, 0));
    end
    @(negedge clk);
    drive(3'b001, 3'b001, 3'b001, 24'h000055, 1); #1;
    chk("bd_last", exp_o(3'b001, 1, 1, 8'h55, 3'b001, 0));
    @(negedge clk);
    drive(3'b000, 3'b000, 3'b000, 24'h000000, 1); #1;
    chk("bd_done", exp_o(3'b000, 0, 0, 8'h00, 3'b000, 0));
    do_reset();

    // Watchdog disabled: 5000-cycle stall must not revoke
    seen0 = 1'b0;
    seen8 = 1'b0;
    @(negedge clk);
    drive(3'b001, 3'b000, 3'b000, 24'h000066, 1);
    @(negedge clk);
    drive(3'b001, 3'b001, 3'b000, 24'h000066, 1); #1;
    chk_val("dis_grant_start", 32'(grant0), 32'h1);
    repeat (5000) begin
      @(negedge clk);
      drive(3'b001, 3'b000, 3'b000, 24'h000066, 1); #1;
      if (abort0) seen0 = 1'b1;
      if (abort)  seen8 = 1'b1;
    end
    chk_val("dis_no_abort", 32'(seen0), 32'd0);
    chk_val("dis_grant_held", 32'(grant0), 32'h1);
    chk_val("dis_busy", 32'(busy0), 32'd1);
    chk_val("wd8_did_abort", 32'(seen8), 32'd1);
    do_reset();

    // Asynchronous reset mid-frame, then rr_ptr restarts at 0
    @(negedge clk);
    drive(3'b001, 3'b000, 3'b000, 24'h000011, 1);
    @(negedge clk);
    drive(3'b001, 3'b001, 3'b001, 24'h000011, 1); #1;
    chk("ar_frame0", exp_o(3'b001, 1, 1, 8'h11, 3'b001, 0));
    @(negedge clk);
    drive(3'b011, 3'b000, 3'b000, 24'h00B100, 1); #1;
    chk("ar_idle", exp_o(3'b000, 0, 0, 8'h00, 3'b000, 0));
    @(negedge clk);
    drive(3'b011, 3'b010, 3'b000, 24'h00B100, 1); #1;
    chk("ar_byte1", exp_o(3'b010, 1, 1, 8'hB1, 3'b010, 0));
    @(negedge clk);
    drive(3'b011, 3'b010, 3'b000, 24'h00B200, 1); #1;
    chk("ar_byte2", exp_o(3'b010, 1, 1, 8'hB2, 3'b010, 0));
    #1 rst_n = 1'b0;
    #1;
    chk("ar_async_drop", exp_o(3'b000, 0, 0, 8'h00, 3'b000, 0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(3'b011, 3'b000, 3'b000, 24'h00B200, 1); #1;
    chk("ar_regrant0", exp_o(3'b001, 1, 0, 8'h00, 3'b001, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hedios_tx_arbiter.md
Name: hedios_tx_arbiter

Overview:
- Round-robin, frame-atomic arbiter that shares the single byte-wide UART transmit path of the Hedios endpoint between N requesters.
- Example requesters: slot telemetry streamer, action acknowledger, debug printer.
- Sits between the requesters and the UART TX byte interface.
- Holds a grant for a whole frame, from first byte through the byte flagged last, so frames never interleave on the wire.
- An idle-mid-frame watchdog reclaims the link from stalled requesters.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_W, 8, byte width of each requester data lane.
- TIMEOUT, 1024, cycles a granted requester may hold in_valid low mid-frame before the grant is revoked; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req  in  N_REQ  per-requester frame request; level-sensitive.
- in_data  in  N_REQ*DATA_W  packed byte lanes; lane i is bits [i*DATA_W +: DATA_W].
- in_valid  in  N_REQ  per-lane byte valid.
- in_last  in  N_REQ  per-lane last-byte-of-frame flag; qualified by in_valid.
- in_ready  out  N_REQ  per-lane accept.
- tx_data  out  DATA_W  byte to UART transmitter.
- tx_valid  out  1  byte valid to transmitter.
- tx_ready  in  1  transmitter can accept a byte.
- grant  out  N_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high while any grant is held.
- abort  out  1  single-cycle pulse when a grant is revoked by the watchdog.
- abort_id  out  clog2(N_REQ)  index of the aborted requester; valid while abort is high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE, rr_ptr = 0, watchdog count = 0.
  - grant = 0, busy = 0, abort = 0, abort_id = 0.
  - tx_valid = 0, in_ready = 0, tx_data = 0.
- States: IDLE and OWN.
- IDLE:
  - in_ready = 0, tx_valid = 0.
  - If req != 0: select the first set bit scanning upward from rr_ptr, wrapping at N_REQ-1 -> 0.
  - Register the one-hot grant and enter OWN. Grant appears the cycle after req is sampled (1-cycle latency).
- OWN with owner g:
  - tx_data = lane g, tx_valid = in_valid[g], in_ready[g] = tx_ready; all other in_ready = 0.
  - These paths are combinational; the arbiter adds no pipeline stage.
  - Transfer = tx_valid & tx_ready.
  - Transfer with in_last[g] = 1: next cycle grant = 0, state = IDLE, rr_ptr = (g+1) mod N_REQ.
  - This gives one dead cycle between frames.
  - Deasserting req[g] mid-frame is ignored; the grant is held until last or timeout.
  - Other requesters' req changes have no effect while in OWN.
- Watchdog (TIMEOUT > 0):
  - Counter clears on entry to OWN and on every cycle where in_valid[g] = 1.
  - Cycles with tx_valid high but tx_ready low (back-pressure) count as valid and never time out.
  - Otherwise the counter increments each OWN cycle.
  - When count reaches TIMEOUT-1 with in_valid[g] still low: next cycle abort = 1, abort_id = g, grant = 0, state = IDLE, rr_ptr = (g+1) mod N_REQ.
  - If in_valid[g] rises on the same cycle the count reaches TIMEOUT-1, the valid wins: counter clears, no abort.
- Counter width = clog2(TIMEOUT+1) and saturates; it never wraps.
- busy = (state == OWN).
- rst_n asserted mid-frame: the grant drops immediately and the byte in flight is not completed. Downstream framing recovery is not this block's responsibility.

Test Plan:
- Single frame, N_REQ=3:
  - Stimulus: req[1] held; lane 1 sends 0xA5, 0x5A, 0x3C (last on 0x3C); tx_ready = 1.
  - Required: grant = 3'b010 one cycle after req; tx_data sequence A5, 5A, 3C; grant = 0 the cycle after 0x3C transfers; rr_ptr = 2.
- Round-robin fairness:
  - Stimulus: all three req held continuously; each frame is 2 bytes.
  - Required: grant sequence 001, 010, 100, 001, with one idle cycle between grants.
- Frame atomicity under back-pressure:
  - Stimulus: requester 0 owns; tx_ready toggles 1,0,0,1; req[2] rises mid-frame.
  - Required: in_ready[2] stays 0; grant stays 001 until lane 0's last byte transfers; then grant = 100.
- Watchdog abort, TIMEOUT=8:
  - Stimulus: requester 2 sends 1 byte without last, then drops in_valid.
  - Required: abort pulses for exactly 1 cycle, 8 cycles after the last valid; abort_id = 2; grant = 0; the next grant goes to requester 0 if it is requesting.
- Watchdog boundary and disable:
  - Stimulus: in_valid rises exactly at count TIMEOUT-1.
  - Required: no abort. With TIMEOUT=0 and a 5000-cycle stall, no abort and the grant is held.
- Asynchronous reset mid-frame:
  - Stimulus: rst_n pulsed low between clock edges during byte 2 of 4.
  - Required: grant, busy, tx_valid and in_ready go 0 without waiting for a clock edge. After release, the first grant goes to the lowest requesting index (rr_ptr = 0).
